fetch_stage: RTL and testbench

- Instruction-fetch front end of the RISC-V pipeline.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with a valid-only response channel.
- Presents the fetched instruction and its PC to the IF/ID pipeline register, honouring stall and branch/jump redirect.
- One outstanding memory request maximum; one-entry skid buffer absorbs a response that lands while the downstream stage is stalled.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch front end: PC, imem request/response, IF/ID output.
// Optional FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    state_t          state;
    state_t          state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            hs;
    logic            load_rsp;
    logic            load_skid;
    logic            cap_skid;
    logic            redirect_unused;

    assign redirect_unused = ^redirect_pc[1:0];
    assign imem_req_valid  = rst && (state == S_REQ);
    assign imem_req_addr   = pc;
    assign hs              = imem_req_valid && imem_req_ready;

    // Next-state, next-pc and output-load decisions; redirect wins over all.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        load_rsp  = 1'b0;
        load_skid = 1'b0;
        cap_skid  = 1'b0;
        if (redirect_valid) begin
            pc_n = {redirect_pc[XLEN-1:2], 2'b00};
            unique case (state)
                S_REQ:   state_n = hs ? S_DROP : S_REQ;
                S_WAIT:  state_n = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  state_n = S_REQ;
                default: state_n = S_DROP;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (hs) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        pc_n = pc + PC_STEP;
                        if (!stall || !if_valid) begin
                            load_rsp = 1'b1;
                            state_n  = S_REQ;
                        end else begin
                            cap_skid = 1'b1;
                            state_n  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        load_skid = 1'b1;
                        state_n   = S_REQ;
                    end
                end
                default: begin
                    if (imem_rsp_valid) state_n = S_REQ;
                end
            endcase
        end
    end

    // State, PC and skid buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= NOP;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (cap_skid) begin
                skid_pc    <= pc;
                skid_instr <= imem_rsp_data;
            end
        end
    end

    // IF/ID output register: load, hold under stall, or drop valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (load_rsp) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= imem_rsp_data;
        end else if (load_skid) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
        end else if (!stall) begin
            if_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    // Count delivered instructions and cycles spent stalled on a valid one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load_rsp || load_skid)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && if_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Main instance at RESET_PC=0x100, second instance at 0xFFFF_FFFC for wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        w_stall;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] w_perf_fetch_cnt;
    logic [31:0] w_perf_stall_cnt;
`endif

    int          checks;
    int          errors;
    logic        mem_auto;
    logic        hs_pend;
    logic [31:0] addr_pend;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk            (clk),
        .rst            (rst),
        .stall          (w_stall),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .if_valid       (w_if_valid),
        .if_pc          (w_if_pc),
        .if_instr       (w_if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (w_perf_fetch_cnt),
        .perf_stall_cnt (w_perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // One clock: zero-wait memory answers one cycle after the handshake.
    task automatic tick();
        hs_pend   = mem_auto && imem_req_valid && imem_req_ready;
        addr_pend = imem_req_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_rsp_valid = hs_pend;
            imem_rsp_data  = addr_pend ^ 32'h0000_A5A5;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b pc=%h, want 0/0", if_valid, if_pc);
        end
        checks++;
        if (if_instr !== 32'h0000_0013) begin
            errors++;
            $display("FAIL reset_instr: got %h want 00000013", if_instr);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || w_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b/%b want 0/0", imem_req_valid, w_req_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_release: valid=%b addr=%h want 1/00000100", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_wait k=%0d: req=%b valid=%b want 0/0", k, imem_req_valid, if_valid);
            end
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h100 + 32'(4 * k) || if_instr !== ((32'h100 + 32'(4 * k)) ^ 32'hA5A5)) begin
                errors++;
                $display("FAIL stream_out k=%0d: valid=%b pc=%h instr=%h want 1/%h/%h", k, if_valid, if_pc, if_instr, 32'h100 + 32'(4 * k), (32'h100 + 32'(4 * k)) ^ 32'hA5A5);
            end
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104 + 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_req k=%0d: valid=%b addr=%h want 1/%h", k, imem_req_valid, imem_req_addr, 32'h104 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== 32'h0000_A4A1) begin
            errors++;
            $display("FAIL stall_hold: valid=%b pc=%h instr=%h want 1/00000104/0000a4a1", if_valid, if_pc, if_instr);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || if_pc !== 32'h104) begin
            errors++;
            $display("FAIL stall_noreq: req=%b pc=%h want 0/00000104", imem_req_valid, if_pc);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h108 || if_instr !== 32'h0000_A4AD) begin
            errors++;
            $display("FAIL stall_skid: valid=%b pc=%h instr=%h want 1/00000108/0000a4ad", if_valid, if_pc, if_instr);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10C) begin
            errors++;
            $display("FAIL stall_next: req=%b addr=%h want 1/0000010c", imem_req_valid, imem_req_addr);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd3 || perf_stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_cnt: fetch=%0d stall=%0d want 3/3", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h10C) begin
            errors++;
            $display("FAIL after_stall: valid=%b pc=%h want 1/0000010c", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_wait();
        mem_auto = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait_drop: valid=%b req=%b want 0/0", if_valid, imem_req_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL redir_wait_req: valid=%b req=%b addr=%h want 0/1/00000200", if_valid, imem_req_valid, imem_req_addr);
        end
        mem_auto = 1'b1;
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h0000_A7A5) begin
            errors++;
            $display("FAIL redir_wait_out: valid=%b pc=%h instr=%h want 1/00000200/0000a7a5", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_rsp();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            errors++;
            $display("FAIL redir_rsp: valid=%b req=%b addr=%h want 0/1/00000300", if_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_hs();
        imem_req_ready = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            errors++;
            $display("FAIL req_stable: req=%b addr=%h want 1/00000300", imem_req_valid, imem_req_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h404;
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h404) begin
            errors++;
            $display("FAIL redir_req_nohs: req=%b addr=%h want 1/00000404", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        redirect_pc    = 32'h500;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_hs_drop: req=%b valid=%b want 0/0", imem_req_valid, if_valid);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500) begin
            errors++;
            $display("FAIL redir_hs_req: valid=%b req=%b addr=%h want 0/1/00000500", if_valid, imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h500 || if_instr !== 32'h0000_A0A5) begin
            errors++;
            $display("FAIL redir_hs_out: valid=%b pc=%h instr=%h want 1/00000500/0000a0a5", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_reset_mid();
        mem_auto       = 1'b0;
        imem_rsp_valid = 1'b0;
        stall          = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || if_instr !== 32'h13) begin
            errors++;
            $display("FAIL rst_mid: valid=%b req=%b instr=%h want 0/0/00000013", if_valid, imem_req_valid, if_instr);
        end
        tick();
        rst   = 1'b1;
        stall = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL rst_mid_req: req=%b addr=%h want 1/00000100", imem_req_valid, imem_req_addr);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        tick();
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_late: valid=%b req=%b want 0/0", if_valid, imem_req_valid);
        end
        imem_rsp_data = 32'h0000_A4A5;
        tick();
        imem_rsp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h0000_A4A5) begin
            errors++;
            $display("FAIL rst_mid_out: valid=%b pc=%h instr=%h want 1/00000100/0000a4a5", if_valid, if_pc, if_instr);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd1 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst: fetch=%0d stall=%0d want 1/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_wrap();
        checks++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req0: req=%b addr=%h want 1/fffffffc", w_req_valid, w_req_addr);
        end
        w_req_ready = 1'b1;
        tick();
        w_rsp_valid = 1'b1;
        w_rsp_data  = 32'hCAFE_0001;
        tick();
        w_rsp_valid = 1'b0;
        checks++;
        if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC || w_if_instr !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL wrap_out0: valid=%b pc=%h instr=%h want 1/fffffffc/cafe0001", w_if_valid, w_if_pc, w_if_instr);
        end
        checks++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req1: req=%b addr=%h want 1/00000000", w_req_valid, w_req_addr);
        end
        tick();
        w_rsp_valid = 1'b1;
        w_rsp_data  = 32'h1357_9BDF;
        tick();
        w_rsp_valid = 1'b0;
        checks++;
        if (w_if_valid !== 1'b1 || w_if_pc !== 32'h0 || w_if_instr !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL wrap_out1: valid=%b pc=%h instr=%h want 1/00000000/13579bdf", w_if_valid, w_if_pc, w_if_instr);
        end
        checks++;
        if (w_req_addr !== 32'h4) begin
            errors++;
            $display("FAIL wrap_req2: addr=%h want 00000004", w_req_addr);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (w_perf_fetch_cnt !== 32'd2) begin
            errors++;
            $display("FAIL wrap_perf: fetch=%0d want 2", w_perf_fetch_cnt);
        end
`endif
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        stall            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        imem_req_ready   = 1'b1;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = 32'h0;
        w_stall          = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;
        w_req_ready      = 1'b0;
        w_rsp_valid      = 1'b0;
        w_rsp_data       = 32'h0;
        mem_auto         = 1'b1;
        hs_pend          = 1'b0;
        addr_pend        = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_hs();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
